// File: rtl/alu4_pkg.sv
// Shared definitions for the alu4 slice and its word sequencer.
package alu4_pkg;

   // Word sequencer states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_state_t;

   // alu4 op codes.
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_AND = 2'b01;
   localparam logic [1:0] OP_OR  = 2'b10;
   localparam logic [1:0] OP_XOR = 2'b11;

   // Nibble index width; never below one bit so NIBBLES=1 still has a counter.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/alu4_word_seq.sv
// Word sequencer: runs one WIDTH*NIBBLES-bit operation through an external
// alu4 slice as NIBBLES back-to-back passes, LS nibble first, with the carry
// of each pass registered and fed back as the carry-in of the next.
module alu4_word_seq
   import alu4_pkg::*;
#(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned NIBBLES = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [1:0]                 op_in,
   input  logic                       b_inv_in,
   input  logic                       cin_in,
   input  logic [WIDTH*NIBBLES-1:0]   a_word,
   input  logic [WIDTH*NIBBLES-1:0]   b_word,
   output logic                       busy,
   output logic                       done,
   output logic [WIDTH*NIBBLES-1:0]   result,
   output logic                       c_out,
   output logic                       zero_out,
   output logic                       overflow_out,
   output logic [WIDTH-1:0]           alu_a,
   output logic [WIDTH-1:0]           alu_b,
   output logic                       alu_b_inv,
   output logic                       alu_y,
   output logic [1:0]                 alu_op,
   input  logic [WIDTH-1:0]           alu_s,
   input  logic                       alu_c,
   input  logic                       alu_zero,
   input  logic                       alu_overflow
);

   localparam int unsigned W    = WIDTH * NIBBLES;
   localparam int unsigned IDXW = idx_width(NIBBLES);

   seq_state_t        r_state;
   seq_state_t        w_next_state;
   logic              w_accept;
   logic              w_pass;
   logic              w_last;

   logic [W-1:0]      r_a;
   logic [W-1:0]      r_b;
   logic [1:0]        r_op;
   logic              r_b_inv;
   logic [IDXW-1:0]   r_idx;
   logic              r_carry;
   logic              r_zacc;
   logic [W-1:0]      r_result;
   logic              r_cout;
   logic              r_ovf;
   logic              r_zero;
   logic [WIDTH-1:0]  w_a_nib;
   logic [WIDTH-1:0]  w_b_nib;

   assign w_pass = (r_state == RUN);
   assign w_last = (r_idx == IDXW'(NIBBLES - 1));

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next_state;
   end

   // Next-state decode and accept strobe.
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_accept     = 1'b1;
               w_next_state = RUN;
            end
         end
         RUN:     if (w_last) w_next_state = DONE;
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Operand latch, nibble counter, carry chain and result assembly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_op     <= '0;
         r_b_inv  <= 1'b0;
         r_idx    <= '0;
         r_carry  <= 1'b0;
         r_zacc   <= 1'b0;
         r_result <= '0;
         r_cout   <= 1'b0;
         r_ovf    <= 1'b0;
         r_zero   <= 1'b0;
      end else if (w_accept) begin
         r_a      <= a_word;
         r_b      <= b_word;
         r_op     <= op_in;
         r_b_inv  <= b_inv_in;
         r_idx    <= '0;
         r_carry  <= cin_in;
         r_zacc   <= 1'b1;
         r_result <= '0;
         r_cout   <= 1'b0;
         r_ovf    <= 1'b0;
         r_zero   <= 1'b0;
      end else if (w_pass) begin
         for (int unsigned n = 0; n < NIBBLES; n++) begin
            if (r_idx == IDXW'(n)) r_result[n*WIDTH +: WIDTH] <= alu_s;
         end
         r_carry <= alu_c;
         r_zacc  <= r_zacc & alu_zero;
         if (w_last) begin
            r_cout <= alu_c;
            r_ovf  <= alu_overflow;
            r_zero <= r_zacc & alu_zero;
         end else begin
            r_idx <= r_idx + IDXW'(1);
         end
      end
   end

   // Select the current nibble of the latched operands.
   always_comb begin
      w_a_nib = '0;
      w_b_nib = '0;
      for (int unsigned n = 0; n < NIBBLES; n++) begin
         if (r_idx == IDXW'(n)) begin
            w_a_nib = r_a[n*WIDTH +: WIDTH];
            w_b_nib = r_b[n*WIDTH +: WIDTH];
         end
      end
   end

   assign busy         = (r_state != IDLE);
   assign done         = (r_state == DONE);
   assign result       = r_result;
   assign c_out        = r_cout;
   assign zero_out     = r_zero;
   assign overflow_out = r_ovf;

   // ALU drive is live only during passes; quiet at zero otherwise.
   assign alu_a     = w_pass ? w_a_nib : '0;
   assign alu_b     = w_pass ? w_b_nib : '0;
   assign alu_b_inv = w_pass & r_b_inv;
   assign alu_y     = w_pass & r_carry;
   assign alu_op    = w_pass ? r_op : '0;

endmodule

// File: tb/tb_alu4_word_seq.sv
// Self-checking bench for alu4_word_seq with a behavioural alu4 slice attached.
module tb_alu4_word_seq;
   import alu4_pkg::*;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  op_in;
   logic        b_inv_in;
   logic        cin_in;
   logic [15:0] a_word;
   logic [15:0] b_word;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic        c_out;
   logic        zero_out;
   logic        overflow_out;
   logic [3:0]  alu_a;
   logic [3:0]  alu_b;
   logic        alu_b_inv;
   logic        alu_y;
   logic [1:0]  alu_op;
   logic [3:0]  alu_s;
   logic        alu_c;
   logic        alu_zero;
   logic        alu_overflow;

   int n_vec = 0;
   int n_err = 0;

   alu4_word_seq #(.WIDTH(4), .NIBBLES(4)) dut (
      .clk(clk), .rst(rst), .start(start), .op_in(op_in), .b_inv_in(b_inv_in),
      .cin_in(cin_in), .a_word(a_word), .b_word(b_word), .busy(busy), .done(done),
      .result(result), .c_out(c_out), .zero_out(zero_out), .overflow_out(overflow_out),
      .alu_a(alu_a), .alu_b(alu_b), .alu_b_inv(alu_b_inv), .alu_y(alu_y), .alu_op(alu_op),
      .alu_s(alu_s), .alu_c(alu_c), .alu_zero(alu_zero), .alu_overflow(alu_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural 4-bit ALU slice: B optionally inverted, Y is carry-in.
   logic [3:0] w_beff;
   logic [4:0] w_sum5;
   always_comb begin
      w_beff       = alu_b ^ {4{alu_b_inv}};
      w_sum5       = {1'b0, alu_a} + {1'b0, w_beff} + {4'b0, alu_y};
      alu_s        = '0;
      alu_c        = 1'b0;
      alu_overflow = 1'b0;
      case (alu_op)
         OP_ADD: begin
            alu_s        = w_sum5[3:0];
            alu_c        = w_sum5[4];
            alu_overflow = (alu_a[3] == w_beff[3]) && (w_sum5[3] != alu_a[3]);
         end
         OP_AND:  alu_s = alu_a & w_beff;
         OP_OR:   alu_s = alu_a | w_beff;
         default: alu_s = alu_a ^ w_beff;
      endcase
      alu_zero = (alu_s == 4'h0);
   end

   // Word-level reference: whole 16-bit arithmetic, no nibble decomposition.
   typedef struct packed {
      logic [15:0] res;
      logic        c;
      logic        z;
      logic        v;
   } ref_t;

   function automatic ref_t ref_calc(input logic [1:0] op, input logic binv, input logic cin,
                                     input logic [15:0] a, input logic [15:0] b);
      ref_t r;
      int unsigned bb;
      int unsigned sum;
      int sa, sb, ss;
      bb = binv ? (32'hFFFF - 32'(b)) : 32'(b);
      r  = '0;
      case (op)
         OP_ADD: begin
            sum   = 32'(a) + bb + 32'(cin);
            r.res = 16'(sum % 65536);
            r.c   = (sum >= 65536);
            sa    = (a >= 16'h8000) ? int'(a) - 65536 : int'(a);
            sb    = (bb >= 32'h8000) ? int'(bb) - 65536 : int'(bb);
            ss    = sa + sb + int'(cin);
            r.v   = (ss > 32767) || (ss < -32768);
         end
         OP_AND:  r.res = a & 16'(bb);
         OP_OR:   r.res = a | 16'(bb);
         default: r.res = a ^ 16'(bb);
      endcase
      r.z = (r.res == 16'h0000);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full operation: accept, passes, done, then one idle cycle.
   task automatic do_op(input string tag, input logic [1:0] op, input logic binv, input logic cin,
                        input logic [15:0] a, input logic [15:0] b,
                        output logic [3:0] ys, output logic ov3);
      ref_t e;
      int   lat;
      e = ref_calc(op, binv, cin, a, b);
      @(negedge clk);
      op_in = op; b_inv_in = binv; cin_in = cin; a_word = a; b_word = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a_word = 16'($urandom); b_word = 16'($urandom);
      op_in = 2'($urandom); b_inv_in = 1'($urandom); cin_in = 1'($urandom);
      chk({tag, ".clr"}, 32'({result, c_out, zero_out, overflow_out}), 32'h0);
      chk({tag, ".busy"}, 32'(busy), 32'h1);
      lat = 1; ys = '0; ov3 = 1'b0;
      while (!done && lat < 20) begin
         if (lat <= 4) ys[lat-1] = alu_y;
         if (lat == 4) ov3 = alu_overflow;
         @(negedge clk);
         lat++;
      end
      chk({tag, ".lat"}, 32'(lat), 32'd5);
      chk({tag, ".res"}, 32'(result), 32'(e.res));
      chk({tag, ".flags"}, 32'({c_out, zero_out, overflow_out}), 32'({e.c, e.z, e.v}));
      @(negedge clk);
      chk({tag, ".idle"}, 32'({done, busy, alu_a, alu_b, alu_b_inv, alu_y, alu_op}), 32'h0);
      chk({tag, ".hold"}, 32'({result, c_out, zero_out, overflow_out}),
          32'({e.res, e.c, e.z, e.v}));
   endtask

   initial begin
      logic [3:0] ys;
      logic       ov3;
      ref_t       e;
      int         dn, d1, d2, lat;

      rst = 1'b1; start = 1'b0; op_in = '0; b_inv_in = 1'b0; cin_in = 1'b0;
      a_word = '0; b_word = '0;
      repeat (3) @(negedge clk);
      chk("reset.res", 32'(result), 32'h0);
      chk("reset.ctl", 32'({busy, done, c_out, zero_out, overflow_out,
                            alu_a, alu_b, alu_b_inv, alu_y, alu_op}), 32'h0);
      rst = 1'b0;

      do_op("add1", OP_ADD, 1'b0, 1'b0, 16'h1234, 16'h0FFF, ys, ov3);
      do_op("add2", OP_ADD, 1'b0, 1'b0, 16'hFFFF, 16'h0001, ys, ov3);
      chk("add2.ychain", 32'(ys), 32'b1110);
      do_op("sub1", OP_ADD, 1'b1, 1'b1, 16'h0005, 16'h0007, ys, ov3);
      do_op("sub2", OP_ADD, 1'b1, 1'b1, 16'h0007, 16'h0005, ys, ov3);
      do_op("ovf1", OP_ADD, 1'b0, 1'b0, 16'h7FFF, 16'h0001, ys, ov3);
      chk("ovf1.pass3", 32'(ov3), 32'(1'b1));
      do_op("ovf2", OP_ADD, 1'b0, 1'b0, 16'h8000, 16'h8000, ys, ov3);
      chk("ovf2.pass3", 32'(ov3), 32'(1'b1));
      do_op("and", OP_AND, 1'b0, 1'b1, 16'hF0F0, 16'h0FF0, ys, ov3);
      do_op("xor0", OP_XOR, 1'b0, 1'b0, 16'hA5A5, 16'hA5A5, ys, ov3);

      for (int i = 0; i < 24; i++) begin
         do_op("rand", 2'($urandom), 1'($urandom), 1'($urandom),
               16'($urandom), 16'($urandom), ys, ov3);
      end

      // start held for 12 cycles: accepts at cycles 0 and 6 only.
      op_in = OP_ADD; b_inv_in = 1'b0; cin_in = 1'b1; a_word = 16'h0F0F; b_word = 16'h1111;
      e = ref_calc(OP_ADD, 1'b0, 1'b1, 16'h0F0F, 16'h1111);
      dn = 0; d1 = -1; d2 = -1;
      for (int c = 0; c < 20; c++) begin
         if (done) begin
            dn++;
            if (dn == 1) d1 = c; else d2 = c;
         end
         start = (c < 12);
         @(negedge clk);
      end
      start = 1'b0;
      chk("burst.count", 32'(dn), 32'd2);
      chk("burst.d1", 32'(d1), 32'd5);
      chk("burst.d2", 32'(d2), 32'd11);
      chk("burst.res", 32'(result), 32'(e.res));

      // Reset during pass 2.
      @(negedge clk);
      op_in = OP_ADD; b_inv_in = 1'b0; cin_in = 1'b0; a_word = 16'hBEEF; b_word = 16'h1357;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (lat < 3) begin
         @(negedge clk);
         lat++;
      end
      chk("mid.alu_a", 32'(alu_a), 32'hE);
      rst = 1'b1;
      #1;
      chk("mid.rst.res", 32'(result), 32'h0);
      chk("mid.rst.ctl", 32'({busy, done, c_out, zero_out, overflow_out,
                              alu_a, alu_b, alu_b_inv, alu_y, alu_op}), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      dn = 0;
      repeat (8) begin
         @(negedge clk);
         if (done) dn++;
      end
      chk("mid.nodone", 32'(dn), 32'd0);
      do_op("after", OP_ADD, 1'b0, 1'b0, 16'h00FF, 16'h0001, ys, ov3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
